// File: rtl/spi_pkg.sv
// Shared types, func codes and the word transform for the SPI transfer slave.
package spi_pkg;

  localparam int unsigned MAX_W = 32;
  localparam int unsigned IDX_W = $clog2(MAX_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] FUNC_REV    = 2'b00;
  localparam logic [1:0] FUNC_ECHO   = 2'b01;
  localparam logic [1:0] FUNC_INV    = 2'b10;
  localparam logic [1:0] FUNC_REVINV = 2'b11;

  // Transform the low `width` bits of word; bits above width are returned as 0.
  function automatic logic [MAX_W-1:0] spi_transform(input logic [1:0] func,
                                                     input logic [MAX_W-1:0] word,
                                                     input int unsigned width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] src;
    logic [MAX_W-1:0] rev;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    src  = ((func == FUNC_INV) || (func == FUNC_REVINV)) ? (~word & mask) : (word & mask);
    rev  = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) rev[IDX_W'(i)] = src[IDX_W'(width - 1 - i)];
    end
    return ((func == FUNC_REV) || (func == FUNC_REVINV)) ? rev : src;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = q & ~prev_q;
  assign fall_c = ~q & prev_q;

endmodule

// File: rtl/spi_xfer_slave.sv
// Oversampling half-duplex SPI slave: receive a word, then return a transformed word.
module spi_xfer_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  input  logic [1:0]        func,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .d(sck),
    .q(sck_lvl_unused), .rise_c(sck_rise), .fall_c(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset_n(reset_n), .d(ss),
    .q(ss_s), .rise_c(ss_rise), .fall_c(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .d(mosi),
    .q(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  logic lead_c, trail_c, sample_c, drive_c;
  assign lead_c   = CPOL ? sck_fall : sck_rise;
  assign trail_c  = CPOL ? sck_rise : sck_fall;
  assign sample_c = CPHA ? trail_c : lead_c;
  assign drive_c  = CPHA ? lead_c : trail_c;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_d;
  logic [1:0]          func_q, func_d;
  logic                miso_d, oe_d, done_d, abort_d;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic                armed_q, armed_d;
  logic                last_bit_c;
  logic [DATA_W-1:0]   rx_word_c;

  assign last_bit_c = (cnt_q == CNT_W'(DATA_W - 1));
  assign rx_word_c  = {shift_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      func_q      <= FUNC_REV;
      miso        <= 1'b1;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      func_q      <= func_d;
      miso        <= miso_d;
      miso_oe     <= oe_d;
      rx_data     <= rx_d;
      frame_done  <= done_d;
      frame_abort <= abort_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  // A frame may only start once ss has been seen high after the synchroniser refilled post-reset.
  always_comb begin
    flush_d = flush_q;
    armed_d = armed_q;
    if (flush_q != FLUSH_W'(SYNC_STAGES)) flush_d = flush_q + FLUSH_W'(1);
    else if (ss_s) armed_d = 1'b1;
  end

  // Frame sequencing; ss rising overrides any clock edge in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    func_d  = func_q;
    miso_d  = miso;
    oe_d    = miso_oe;
    rx_d    = rx_data;
    done_d  = 1'b0;
    abort_d = 1'b0;

    if (ss_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b1;
      oe_d    = 1'b0;
      abort_d = (state_q == RX) || (state_q == TX);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall && armed_q) begin
            state_d = RX;
            func_d  = func;
            cnt_d   = '0;
            shift_d = '0;
            oe_d    = 1'b1;
            miso_d  = 1'b1;
          end
        end
        RX: begin
          if (sample_c) begin
            shift_d = rx_word_c;
            if (last_bit_c) begin
              rx_d    = rx_word_c;
              tx_d    = DATA_W'(spi_transform(func_q, MAX_W'(rx_word_c), DATA_W));
              cnt_d   = '0;
              state_d = TX;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        TX: begin
          if (drive_c) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sample_c) begin
            if (last_bit_c) begin
              done_d  = 1'b1;
              cnt_d   = '0;
              miso_d  = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          miso_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_slave.sv
// Directed bench for spi_xfer_slave: mode 0 / 8-bit and mode 3 / 16-bit instances.
module tb_spi_xfer_slave;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       sck0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b1;
  logic [1:0] func0 = 2'b00;
  logic       miso0, oe0, done0, abort0;
  logic [7:0] rx0;

  logic        sck3 = 1'b1, ss3 = 1'b1, mosi3 = 1'b1;
  logic [1:0]  func3 = 2'b11;
  logic        miso3, oe3, done3, abort3;
  logic [15:0] rx3;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt0 = 0, abort_cnt0 = 0, done_cnt3 = 0, abort_cnt3 = 0;

  always #5 clk = ~clk;

  spi_xfer_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
    .clock(clk), .reset_n(rst_n), .sck(sck0), .ss(ss0), .mosi(mosi0), .func(func0),
    .miso(miso0), .miso_oe(oe0), .rx_data(rx0), .frame_done(done0), .frame_abort(abort0)
  );

  spi_xfer_slave #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut3 (
    .clock(clk), .reset_n(rst_n), .sck(sck3), .ss(ss3), .mosi(mosi3), .func(func3),
    .miso(miso3), .miso_oe(oe3), .rx_data(rx3), .frame_done(done3), .frame_abort(abort3)
  );

  always @(negedge clk) begin
    if (done0)  done_cnt0++;
    if (abort0) abort_cnt0++;
    if (done3)  done_cnt3++;
    if (abort3) abort_cnt3++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_sck(input int sel, input logic v);
    if (sel == 1) sck3 = v; else sck0 = v;
  endtask

  task automatic set_ss(input int sel, input logic v);
    if (sel == 1) ss3 = v; else ss0 = v;
  endtask

  task automatic set_mosi(input int sel, input logic v);
    if (sel == 1) mosi3 = v; else mosi0 = v;
  endtask

  function automatic logic get_miso(input int sel);
    return (sel == 1) ? miso3 : miso0;
  endfunction

  // Master shifts n bits of word out MSB-first; ones stays 1 if miso was high throughout.
  task automatic send_bits(input int sel, input logic [31:0] word, input int n, output logic ones);
    logic cpol, cpha;
    logic [31:0] sh;
    cpol = (sel == 1);
    cpha = cpol;
    sh   = word << (32 - n);
    ones = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        set_mosi(sel, sh[31]);
        #HALF;
        ones &= get_miso(sel);
        set_sck(sel, ~cpol);
        #HALF;
        ones &= get_miso(sel);
        set_sck(sel, cpol);
      end else begin
        set_sck(sel, ~cpol);
        set_mosi(sel, sh[31]);
        #HALF;
        ones &= get_miso(sel);
        set_sck(sel, cpol);
        #HALF;
        ones &= get_miso(sel);
      end
      sh = sh << 1;
    end
  endtask

  // Master clocks n bits in, sampling miso just before its sampling edge.
  task automatic recv_bits(input int sel, input int n, output logic [31:0] got);
    logic cpol, cpha;
    cpol = (sel == 1);
    cpha = cpol;
    got  = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        #HALF;
        got = {got[30:0], get_miso(sel)};
        set_sck(sel, ~cpol);
        #HALF;
        set_sck(sel, cpol);
      end else begin
        set_sck(sel, ~cpol);
        #HALF;
        got = {got[30:0], get_miso(sel)};
        set_sck(sel, cpol);
        #HALF;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        ones;
    logic [31:0] got;

    #22;
    check("rst_miso", 32'(miso0), 32'd1);
    check("rst_oe", 32'(oe0), 32'd0);
    check("rst_rx", 32'(rx0), 32'd0);
    check("rst_done_abort", 32'({done0, abort0}), 32'd0);
    check("rst_rx3", 32'(rx3), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: reverse 0x01 -> 0x80
    func0 = 2'b00;
    set_ss(0, 1'b0);
    #100;
    check("t1_oe", 32'(oe0), 32'd1);
    send_bits(0, 32'h01, 8, ones);
    recv_bits(0, 8, got);
    #100;
    check("t1_miso_high_rx", 32'(ones), 32'd1);
    check("t1_tx", got, 32'h80);
    check("t1_rx", 32'(rx0), 32'h01);
    check("t1_done_cnt", 32'(done_cnt0), 32'd1);
    set_ss(0, 1'b1);
    #100;
    check("t1_oe_off", 32'(oe0), 32'd0);
    check("t1_no_abort", 32'(abort_cnt0), 32'd0);

    // 2: invert 0xA5 -> 0x5A, echo 0x3C with a func change mid-frame
    func0 = 2'b10;
    set_ss(0, 1'b0);
    #100;
    send_bits(0, 32'hA5, 8, ones);
    recv_bits(0, 8, got);
    #100;
    check("t2_inv_tx", got, 32'h5A);
    check("t2_inv_rx", 32'(rx0), 32'hA5);
    set_ss(0, 1'b1);
    #100;
    func0 = 2'b01;
    set_ss(0, 1'b0);
    #100;
    func0 = 2'b00;
    send_bits(0, 32'h3C, 8, ones);
    recv_bits(0, 8, got);
    #100;
    check("t2_echo_tx", got, 32'h3C);
    check("t2_done_cnt", 32'(done_cnt0), 32'd3);
    set_ss(0, 1'b1);
    #100;

    // 3: mode 3, 16-bit, reverse-of-invert 0x00F0 -> 0xF0FF
    func3 = 2'b11;
    set_ss(1, 1'b0);
    #100;
    send_bits(1, 32'h00F0, 16, ones);
    recv_bits(1, 16, got);
    #100;
    check("t3_miso_high_rx", 32'(ones), 32'd1);
    check("t3_tx", got, 32'hF0FF);
    check("t3_rx", 32'(rx3), 32'h00F0);
    check("t3_done_cnt", 32'(done_cnt3), 32'd1);
    set_ss(1, 1'b1);
    #100;
    check("t3_oe_off", 32'(oe3), 32'd0);
    check("t3_no_abort", 32'(abort_cnt3), 32'd0);

    // 4: abort after 5 RX bits, then a clean frame
    func0 = 2'b00;
    set_ss(0, 1'b0);
    #100;
    send_bits(0, 32'h1F, 5, ones);
    #100;
    set_ss(0, 1'b1);
    #100;
    check("t4_abort_cnt", 32'(abort_cnt0), 32'd1);
    check("t4_no_done", 32'(done_cnt0), 32'd3);
    check("t4_rx_kept", 32'(rx0), 32'h3C);
    check("t4_oe_off", 32'(oe0), 32'd0);
    set_ss(0, 1'b0);
    #100;
    send_bits(0, 32'h02, 8, ones);
    recv_bits(0, 8, got);
    #100;
    check("t4_tx", got, 32'h40);
    check("t4_done_cnt", 32'(done_cnt0), 32'd4);

    // 5: extra clocks after DONE are ignored
    recv_bits(0, 8, got);
    #100;
    check("t5_miso_idle", got, 32'hFF);
    check("t5_no_pulses", 32'({done_cnt0[15:0], abort_cnt0[15:0]}), 32'h0004_0001);
    set_ss(0, 1'b1);
    #100;
    check("t5_oe_off", 32'(oe0), 32'd0);
    check("t5_no_abort", 32'(abort_cnt0), 32'd1);

    // 6: reset during TX bit 3
    set_ss(0, 1'b0);
    #100;
    send_bits(0, 32'h55, 8, ones);
    recv_bits(0, 3, got);
    check("t6_tx_partial", got, 32'h5);
    check("t6_rx_pre", 32'(rx0), 32'h55);
    #40;
    rst_n = 1'b0;
    #1;
    check("t6_rst_miso", 32'(miso0), 32'd1);
    check("t6_rst_oe", 32'(oe0), 32'd0);
    check("t6_rst_rx", 32'(rx0), 32'd0);
    check("t6_rst_pulses", 32'({done0, abort0}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #100;
    send_bits(0, 32'h80, 8, ones);
    recv_bits(0, 8, got);
    #100;
    check("t6_no_start_oe", 32'(oe0), 32'd0);
    check("t6_no_start_miso", got, 32'hFF);
    check("t6_no_start_done", 32'(done_cnt0), 32'd4);
    set_ss(0, 1'b1);
    #100;
    set_ss(0, 1'b0);
    #100;
    send_bits(0, 32'h80, 8, ones);
    recv_bits(0, 8, got);
    #100;
    check("t6_tx", got, 32'h01);
    check("t6_rx", 32'(rx0), 32'h80);
    check("t6_done_cnt", 32'(done_cnt0), 32'd5);
    set_ss(0, 1'b1);
    #100;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
